spike_rate_encoder: RTL and testbench
=====================================

Name: spike_rate_encoder

Overview:
- Produces the spike vectors consumed by the spike MAC.
- Accepts one frame of INPUT_VEC_LEN unsigned WIDTH-bit intensities.
- Emits NUM_STEPS consecutive INPUT_VEC_LEN-bit spike vectors using deterministic accumulator (carry-out) rate coding.
- Sits between the input frame buffer and the spike MAC. Valid/ready on both sides.

Parameters:
- INPUT_VEC_LEN, 8: number of channels; width of the spike vector.
- WIDTH, 8: bits per input intensity; accumulator width.
- NUM_STEPS, 256: spike vectors emitted per frame; legal range 1..2^WIDTH.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: frame available.
- in_ready  out  1: encoder can accept a frame this cycle.
- in_values  in  [INPUT_VEC_LEN-1:0][WIDTH-1:0]: frame intensities.
- spike_valid  out  1: spikes/spike_step/spike_last valid.
- spike_ready  in  1: downstream accepts the current spike vector.
- spikes  out  [INPUT_VEC_LEN-1:0]: spike vector for the current step.
- spike_step  out  $clog2(NUM_STEPS) (min 1): index of the current step.
- spike_last  out  1: current step is NUM_STEPS-1.

Behaviour:
- Reset values: state IDLE, spike_valid=0, spikes=0, spike_step=0, spike_last=0, all accumulators 0, latched values 0.
- in_ready=1 in IDLE. In RUN it equals (spike_last && spike_ready), a combinational path from spike_ready.
- FSM IDLE -> RUN: in_valid && in_ready. Latch in_values into val[i], clear acc[i], step=0. spike_valid rises the next cycle (1-cycle latency).
- Per step: sum[i] = acc[i] + val[i], computed at WIDTH+1 bits. spikes[i] = sum[i][WIDTH], the carry. spikes is driven combinationally from registered state only.
- Handshake fire = spike_valid && spike_ready:
  - acc[i] <= sum[i][WIDTH-1:0] (wraps modulo 2^WIDTH);
  - step <= step+1.
- Stall (spike_valid && !spike_ready): all outputs held stable; acc and step frozen.
- Frame end, fire with spike_last=1:
  - if in_valid, accept the new frame the same cycle and stay in RUN with step=0 and acc cleared; no bubble;
  - else go to IDLE with spike_valid=0 and spikes=0.
- Spike count per channel over a frame is exactly floor(val*NUM_STEPS/2^WIDTH).
  - With NUM_STEPS=2^WIDTH the count equals val.
  - val=0 never spikes.
  - val=2^WIDTH-1 spikes on every step except step 0.
- NUM_STEPS=1: spike_last is constant 1 during RUN; every frame is a single, all-zero vector.
- in_values changes while not accepted: ignored; only the latched copy is used.
- rst mid-frame: in the next cycle the state is as after reset. The partial frame is discarded, with no further spikes and no spike_last.
- rst has priority over any simultaneous handshake.

Decomposition:
- Shared package (DPE_params): INPUT_VEC_LEN, WIDTH, and a derived STEP_W = max(1, $clog2(NUM_STEPS)) constant.
- Add a two-value state enum typedef (IDLE, RUN) there, alongside the other DPE constants.
- One natural sub-module: spike_rate_channel. It holds one channel's val/acc registers and carry output, with load/advance controls, and is instantiated INPUT_VEC_LEN times from a generate loop.
- The top holds the FSM, step counter and handshake logic.

Test Plan:
- Count check: reset, then a frame of {0,1,2,64,128,200,254,255}, spike_ready=1 -> 256 vectors. Per-channel spike totals are {0,1,2,64,128,200,254,255}. Channel 128 spikes on odd steps only; channel 1 spikes only at step 255. spike_last is high only at step 255.
- Backpressure: the same frame with spike_ready toggled pseudo-randomly -> identical spike sequence. Outputs are stable during every stall cycle; the step index advances only on fire.
- Back-to-back: two frames ({255 x8}, then {0 x8}) with in_valid held high -> the second frame is accepted on the spike_last fire. Step 0 of frame 2 follows with no bubble cycle, and frame 2 emits all-zero vectors.
- Reset mid-frame: assert rst at step 100 -> the next cycle has spike_valid=0 and in_ready=1. A new frame {128 x8} restarts at step 0 with step 0 spikes=0x00 and step 1 spikes=0xFF.
- Parameter sweep: NUM_STEPS=10, frame {255,128,26,25,0,0,0,0} -> 10 vectors with totals {9,5,1,0,0,0,0,0}.
- Parameter edge: NUM_STEPS=1 -> exactly one all-zero vector per frame with spike_last=1.
- Idle hold: in_valid=0 for 50 cycles after reset -> spike_valid stays 0, spikes stays 0, in_ready stays 1.

Source files
------------

// File: rtl/spike_rate_encoder_pkg.sv
// Shared constants and types for the spike rate encoder and its channel slices.
package spike_rate_encoder_pkg;

   localparam int INPUT_VEC_LEN = 8;
   localparam int WIDTH         = 8;
   localparam int NUM_STEPS     = 256;

   function automatic int step_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int STEP_W = step_width(NUM_STEPS);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } enc_state_t;

endpackage

// File: rtl/spike_rate_encoder_channel.sv
// One channel of the rate encoder: latched intensity plus wrapping accumulator.
// The carry out of acc + val is this channel's spike for the current step.
module spike_rate_channel
   import spike_rate_encoder_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         advance,
   input  logic [W-1:0] load_val,
   output logic         carry
);

   logic [W-1:0] val;
   logic [W-1:0] acc;
   logic [W:0]   sum;

   assign sum   = {1'b0, acc} + {1'b0, val};
   assign carry = sum[W];

   // A new frame load wins over advancing the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         val <= '0;
         acc <= '0;
      end else if (load) begin
         val <= load_val;
         acc <= '0;
      end else if (advance) begin
         acc <= sum[W-1:0];
      end
   end

endmodule

// File: rtl/spike_rate_encoder.sv
// Frame-in / spike-vectors-out rate encoder: accepts one intensity frame and
// emits NUM_STEPS spike vectors using accumulator carry-out coding.
//
//   state | meaning
//   IDLE  | no frame held; in_ready=1, spike_valid=0, spikes=0
//   RUN   | emitting steps of the latched frame; new frame taken on last fire
module spike_rate_encoder #(
   parameter int INPUT_VEC_LEN = spike_rate_encoder_pkg::INPUT_VEC_LEN,
   parameter int WIDTH         = spike_rate_encoder_pkg::WIDTH,
   parameter int NUM_STEPS     = spike_rate_encoder_pkg::NUM_STEPS
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]  in_values,
   output logic                                 spike_valid,
   input  logic                                 spike_ready,
   output logic [INPUT_VEC_LEN-1:0]             spikes,
   output logic [spike_rate_encoder_pkg::step_width(NUM_STEPS)-1:0] spike_step,
   output logic                                 spike_last
);
   import spike_rate_encoder_pkg::*;

   localparam int            SW        = step_width(NUM_STEPS);
   localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

   enc_state_t               state;
   enc_state_t               state_nxt;
   logic [SW-1:0]            step;
   logic [INPUT_VEC_LEN-1:0] carry;
   logic                     fire;
   logic                     accept;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // in_ready in RUN is combinational from spike_ready so the next frame can
   // be taken on the last fire without a bubble.
   always_comb begin
      state_nxt   = state;
      spike_valid = (state == RUN);
      spike_last  = (state == RUN) && (step == LAST_STEP);
      spikes      = (state == RUN) ? carry : '0;
      in_ready    = (state == IDLE) || (spike_last && spike_ready);
      fire        = spike_valid && spike_ready;
      accept      = in_valid && in_ready;
      case (state)
         IDLE: if (accept) state_nxt = RUN;
         RUN:  if (fire && spike_last && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step <= '0;
      end else if (accept) begin
         step <= '0;
      end else if (fire) begin
         step <= spike_last ? '0 : step + SW'(1);
      end
   end

   assign spike_step = step;

   for (genvar g = 0; g < INPUT_VEC_LEN; g++) begin : g_chan
      spike_rate_channel #(.W(WIDTH)) u_chan (
         .clk      (clk),
         .rst      (rst),
         .load     (accept),
         .advance  (fire),
         .load_val (in_values[g]),
         .carry    (carry[g])
      );
   end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: closed-form rate-coding model for the default
// instance plus directed runs of NUM_STEPS=10 and NUM_STEPS=1 instances.
module tb_spike_rate_encoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            a_in_valid, a_in_ready, a_spike_valid, a_spike_ready, a_last;
   logic [7:0][7:0] a_in_values;
   logic [7:0]      a_spikes;
   logic [7:0]      a_step;

   logic            b_in_valid, b_in_ready, b_spike_valid, b_spike_ready, b_last;
   logic [7:0][7:0] b_in_values;
   logic [7:0]      b_spikes;
   logic [3:0]      b_step;

   logic            c_in_valid, c_in_ready, c_spike_valid, c_spike_ready, c_last;
   logic [7:0][7:0] c_in_values;
   logic [7:0]      c_spikes;
   logic [0:0]      c_step;

   spike_rate_encoder #(.INPUT_VEC_LEN(8), .WIDTH(8), .NUM_STEPS(256)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_values(a_in_values), .spike_valid(a_spike_valid), .spike_ready(a_spike_ready),
      .spikes(a_spikes), .spike_step(a_step), .spike_last(a_last));

   spike_rate_encoder #(.INPUT_VEC_LEN(8), .WIDTH(8), .NUM_STEPS(10)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_values(b_in_values), .spike_valid(b_spike_valid), .spike_ready(b_spike_ready),
      .spikes(b_spikes), .spike_step(b_step), .spike_last(b_last));

   spike_rate_encoder #(.INPUT_VEC_LEN(8), .WIDTH(8), .NUM_STEPS(1)) dut_c (
      .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_values(c_in_values), .spike_valid(c_spike_valid), .spike_ready(c_spike_ready),
      .spikes(c_spikes), .spike_step(c_step), .spike_last(c_last));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Channel with intensity v fires at step k iff floor(v*k/256) steps up at k+1.
   function automatic bit spike_of(input int v, input int k);
      return (((k + 1) * v) / 256) != ((k * v) / 256);
   endfunction

   // Reference model for dut_a (NUM_STEPS=256).
   bit m_run = 1'b0;
   int m_step = 0;
   int m_vals[8];
   int tot[8];
   int last_tot[8];
   int n_last_fires = 0;

   always @(negedge clk) begin : model_cmp
      bit         m_last;
      bit         exp_ready;
      logic [7:0] exp_sp;
      m_last    = m_run && (m_step == 255);
      exp_ready = !m_run || (m_last && a_spike_ready);
      exp_sp    = '0;
      if (m_run)
         for (int i = 0; i < 8; i++) exp_sp[i] = spike_of(m_vals[i], m_step);
      check("a_spike_valid", a_spike_valid, m_run);
      check("a_in_ready", a_in_ready, exp_ready);
      check("a_spikes", a_spikes, exp_sp);
      if (m_run) begin
         check("a_spike_step", a_step, m_step);
         check("a_spike_last", a_last, m_last);
      end

      if (rst) begin
         for (int i = 0; i < 8; i++) tot[i] = 0;
      end else if (a_spike_valid && a_spike_ready) begin
         for (int i = 0; i < 8; i++) tot[i] += int'(a_spikes[i]);
         if (a_last) begin
            for (int i = 0; i < 8; i++) begin
               last_tot[i] = tot[i];
               tot[i] = 0;
            end
            n_last_fires++;
         end
      end

      if (rst) begin
         m_run = 1'b0;
         m_step = 0;
         for (int i = 0; i < 8; i++) m_vals[i] = 0;
      end else if (a_in_valid && exp_ready) begin
         m_run = 1'b1;
         m_step = 0;
         for (int i = 0; i < 8; i++) m_vals[i] = int'(a_in_values[i]);
      end else if (m_run && a_spike_ready) begin
         if (m_last) begin
            m_run = 1'b0;
            m_step = 0;
         end else begin
            m_step++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input int v[8]);
      for (int i = 0; i < 8; i++) a_in_values[i] = 8'(v[i]);
   endtask

   task automatic send_a(input int v[8]);
      load_a(v);
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      a_in_values = {$urandom(), $urandom()};
   endtask

   task automatic wait_last(input int target, input int budget, input bit random_ready,
                            input string name);
      int n = 0;
      while (n_last_fires < target && n < budget) begin
         if (random_ready) a_spike_ready = 1'($urandom_range(0, 1));
         if (!a_in_valid) a_in_values = {$urandom(), $urandom()};
         tick();
         n++;
      end
      a_spike_ready = 1'b1;
      check(name, (n_last_fires >= target) ? 1 : 0, 1);
   endtask

   task automatic check_tot(input string name, input int exp[8]);
      for (int i = 0; i < 8; i++) check($sformatf("%s_ch%0d", name, i), last_tot[i], exp[i]);
   endtask

   int f_count[8] = '{0, 1, 2, 64, 128, 200, 254, 255};
   int f_255[8]   = '{default: 255};
   int f_0[8]     = '{default: 0};
   int f_128[8]   = '{default: 128};
   int f_b[8]     = '{255, 128, 26, 25, 0, 0, 0, 0};
   int t_b[8]     = '{9, 5, 1, 0, 0, 0, 0, 0};
   int rv[8];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int target;
      int n;
      int nvec;
      int btot[8];
      logic [7:0] exp_sp;

      rst = 1'b1;
      a_in_valid = 1'b0; a_spike_ready = 1'b0; a_in_values = '0;
      b_in_valid = 1'b0; b_spike_ready = 1'b0; b_in_values = '0;
      c_in_valid = 1'b0; c_spike_ready = 1'b0; c_in_values = '0;
      repeat (3) tick();
      check("rst_spike_valid", a_spike_valid, 0);
      check("rst_in_ready", a_in_ready, 1);
      check("rst_spikes", a_spikes, 0);
      check("rst_step", a_step, 0);
      check("rst_last", a_last, 0);
      check("rst_b_valid", b_spike_valid, 0);
      check("rst_c_valid", c_spike_valid, 0);
      rst = 1'b0;

      // Idle hold with garbage on the data lines
      repeat (50) begin
         a_in_values = {$urandom(), $urandom()};
         tick();
      end
      check("idle_valid", a_spike_valid, 0);
      check("idle_ready", a_in_ready, 1);

      // Count check
      target = 0;
      a_spike_ready = 1'b1;
      send_a(f_count);
      target++;
      wait_last(target, 300, 1'b0, "count_done");
      check_tot("count_tot", f_count);

      // Backpressure with the same frame
      send_a(f_count);
      target++;
      wait_last(target, 3000, 1'b1, "bp_done");
      check_tot("bp_tot", f_count);

      // Random frames under random stalls
      repeat (3) begin
         for (int i = 0; i < 8; i++) rv[i] = $urandom_range(0, 255);
         send_a(rv);
         target++;
         wait_last(target, 3000, 1'b1, "rand_done");
         check_tot("rand_tot", rv);
      end

      // Back-to-back frames with in_valid held
      a_spike_ready = 1'b1;
      load_a(f_255);
      a_in_valid = 1'b1;
      tick();
      load_a(f_0);
      target++;
      wait_last(target, 300, 1'b0, "b2b_first_done");
      check("b2b_no_bubble_valid", a_spike_valid, 1);
      check("b2b_no_bubble_step", a_step, 0);
      a_in_valid = 1'b0;
      check_tot("b2b_tot1", f_255);
      target++;
      wait_last(target, 300, 1'b0, "b2b_second_done");
      check_tot("b2b_tot2", f_0);

      // Reset mid-frame
      send_a(f_count);
      n = 0;
      while (!(a_spike_valid && a_step == 8'd100) && n < 300) begin
         tick();
         n++;
      end
      check("mid_reach_step100", (a_spike_valid && a_step == 8'd100) ? 1 : 0, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", a_spike_valid, 0);
      check("mid_rst_ready", a_in_ready, 1);
      check("mid_rst_spikes", a_spikes, 0);
      load_a(f_128);
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      check("mid_s0_step", a_step, 0);
      check("mid_s0_spikes", a_spikes, 8'h00);
      tick();
      check("mid_s1_step", a_step, 1);
      check("mid_s1_spikes", a_spikes, 8'hFF);
      target++;
      wait_last(target, 300, 1'b0, "mid_new_done");
      check_tot("mid_tot", f_128);

      // NUM_STEPS=10 instance
      for (int i = 0; i < 8; i++) begin
         b_in_values[i] = 8'(f_b[i]);
         btot[i] = 0;
      end
      b_spike_ready = 1'b1;
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      nvec = 0;
      repeat (20) begin
         if (b_spike_valid) begin
            exp_sp = '0;
            for (int i = 0; i < 8; i++) begin
               exp_sp[i] = spike_of(f_b[i], nvec);
               btot[i] += int'(b_spikes[i]);
            end
            check("b_spikes", b_spikes, exp_sp);
            check("b_step", b_step, nvec);
            check("b_last", b_last, (nvec == 9) ? 1 : 0);
            nvec++;
         end
         tick();
      end
      check("b_vectors", nvec, 10);
      for (int i = 0; i < 8; i++) check($sformatf("b_tot_ch%0d", i), btot[i], t_b[i]);

      // NUM_STEPS=1 instance, two frames
      c_spike_ready = 1'b1;
      repeat (2) begin
         c_in_values = {$urandom(), $urandom()} | 64'h8080_8080_8080_8080;
         c_in_valid = 1'b1;
         tick();
         c_in_valid = 1'b0;
         nvec = 0;
         repeat (5) begin
            if (c_spike_valid) begin
               check("c_spikes", c_spikes, 0);
               check("c_last", c_last, 1);
               check("c_step", c_step, 0);
               nvec++;
            end
            tick();
         end
         check("c_vectors", nvec, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
